// File: rtl/div_ctrl.sv
// EX-stage controller for a multi-cycle divider: issues operands, stalls the
// pipeline while the divider runs, and presents the result for HI/LO writeback.
module div_ctrl #(
  parameter int LAT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       div_op_i,
  input  logic [31:0]      reg1_i,
  input  logic [31:0]      reg2_i,
  input  logic             flush_i,
  input  logic             hold_i,
  input  logic [63:0]      div_result_i,
  input  logic             div_ready_i,
  output logic             div_start_o,
  output logic             div_annul_o,
  output logic             div_signed_o,
  output logic [31:0]      div_opdata1_o,
  output logic [31:0]      div_opdata2_o,
  output logic             stallreq_o,
  output logic             whilo_o,
  output logic [31:0]      hi_o,
  output logic [31:0]      lo_o,
  output logic             dbz_o,
  output logic [LAT_W-1:0] lat_o,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [LAT_W-1:0] LAT_MAX = '1;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_op1;
  logic [31:0]      r_op2;
  logic             r_signed;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             r_dbz;
  logic [LAT_W-1:0] r_cnt;
  logic [LAT_W-1:0] r_lat;
  logic             w_valid_op;
  logic             w_issue;
  logic             w_capture;
  logic             w_count;

  assign w_valid_op = (div_op_i == 2'b01) || (div_op_i == 2'b10);

  // Handshake: div_start_o stays high from the issue cycle until the cycle
  // div_ready_i is seen; dropping it (or pulsing div_annul_o) frees the divider.
  always_comb begin
    w_next        = r_state;
    div_start_o   = 1'b0;
    div_annul_o   = 1'b0;
    stallreq_o    = 1'b0;
    whilo_o       = 1'b0;
    div_opdata1_o = r_op1;
    div_opdata2_o = r_op2;
    div_signed_o  = r_signed;
    w_issue       = 1'b0;
    w_capture     = 1'b0;
    w_count       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_valid_op && !flush_i) begin
          w_issue       = 1'b1;
          div_start_o   = 1'b1;
          stallreq_o    = 1'b1;
          div_opdata1_o = reg1_i;
          div_opdata2_o = reg2_i;
          div_signed_o  = (div_op_i == 2'b01);
          w_next        = BUSY;
        end
      end
      BUSY: begin
        if (flush_i) begin
          div_annul_o = 1'b1;
          w_next      = IDLE;
        end else if (div_ready_i) begin
          w_capture = 1'b1;
          w_next    = DONE;
        end else begin
          div_start_o = 1'b1;
          stallreq_o  = 1'b1;
          w_count     = 1'b1;
        end
      end
      DONE: begin
        whilo_o = 1'b1;
        if (!hold_i || flush_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op1    <= '0;
      r_op2    <= '0;
      r_signed <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dbz    <= 1'b0;
      r_cnt    <= '0;
      r_lat    <= '0;
    end else begin
      r_state <= w_next;
      if (w_issue) begin
        r_op1    <= reg1_i;
        r_op2    <= reg2_i;
        r_signed <= (div_op_i == 2'b01);
        r_cnt    <= LAT_W'(1);
      end
      if (w_count && (r_cnt != LAT_MAX)) r_cnt <= r_cnt + LAT_W'(1);
      if (w_capture) begin
        r_hi  <= div_result_i[63:32];
        r_lo  <= div_result_i[31:0];
        r_dbz <= (r_op2 == 32'd0);
        r_lat <= (r_cnt == LAT_MAX) ? LAT_MAX : r_cnt + LAT_W'(1);
      end
    end
  end

  assign hi_o        = r_hi;
  assign lo_o        = r_lo;
  assign dbz_o       = r_dbz;
  assign lat_o       = r_lat;
  assign dbg_state_o = r_state;

endmodule
